// File: rtl/keccak_pkg.sv
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared constants, state encoding and the last-word byte-mask
//                helper for the Keccak input packer.
//  Contents    : K_RATE, CHUNK_W, CHUNK_WORDS, CHUNK_BYTES, state_t,
//                last_word_mask()
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keccak_pkg;

    localparam int K_RATE      = 1088;
    localparam int CHUNK_W     = 544;
    localparam int CHUNK_WORDS = 17;
    localparam int CHUNK_BYTES = 68;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Keeps the first s_bytes bytes of a word (byte 0 is the MSB byte) and
    // zeroes the rest. Counts above 4 keep the whole word.
    function automatic logic [31:0] last_word_mask(input logic [2:0] s_bytes);
        logic [31:0] m;
        case (s_bytes)
            3'd0:    m = 32'h0000_0000;
            3'd1:    m = 32'hFF00_0000;
            3'd2:    m = 32'hFFFF_0000;
            3'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_input_packer_if.sv
// ============================================================================
//  Module      : keccak_input_packer_if
//  Description : Word-stream input and padder-chunk output bundle of the
//                Keccak input packer.
//  Signals     : s_word/s_valid/s_last/s_bytes/s_ready  - message word stream
//                out/out_valid/out_last/out_byte_num     - chunk to padder
//                buffer_full                             - padder back-pressure
//  Modports    : slave  - packer view
//                master - environment view (source + padder)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keccak_input_packer_if #(
    parameter int CHUNK_W = 544,
    parameter int WORD_W  = 32
);
    logic [WORD_W-1:0]  s_word;
    logic               s_valid;
    logic               s_last;
    logic [2:0]         s_bytes;
    logic               s_ready;
    logic [CHUNK_W-1:0] out;
    logic               out_valid;
    logic               out_last;
    logic [7:0]         out_byte_num;
    logic               buffer_full;

    modport slave (
        input  s_word, s_valid, s_last, s_bytes, buffer_full,
        output s_ready, out, out_valid, out_last, out_byte_num
    );

    modport master (
        output s_word, s_valid, s_last, s_bytes, buffer_full,
        input  s_ready, out, out_valid, out_last, out_byte_num
    );
endinterface

`default_nettype wire

// File: rtl/keccak_input_packer.sv
// ============================================================================
//  Module      : keccak_input_packer
//  Description : Packs a stream of message words into padder-sized chunks.
//                Word k of a chunk occupies out[CHUNK_W-1-WORD_W*k -: WORD_W].
//                The final word is byte-masked and the final chunk reports its
//                valid byte count. A message that exactly fills a chunk is
//                followed by an all-zero final chunk with zero bytes.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-low reset
//                bus   - keccak_input_packer_if.slave (word in / chunk out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_input_packer #(
    parameter int CHUNK_W = 544,
    parameter int WORD_W  = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    keccak_input_packer_if.slave  bus
);
    import keccak_pkg::*;

    localparam int         SLOTS      = CHUNK_W / WORD_W;
    localparam logic [4:0] LAST_SLOT  = 5'(SLOTS - 1);
    localparam logic [7:0] FULL_BYTES = 8'(CHUNK_W / 8);

    state_t             r_state;
    logic [4:0]         r_cnt;
    logic [CHUNK_W-1:0] r_chunk;
    logic               r_last;
    logic               r_pend_empty;
    logic               r_s_ready;
    logic               r_out_valid;
    logic [7:0]         r_byte_num;

    logic               w_accept;
    logic               w_xfer;
    logic [2:0]         w_bytes_sat;
    logic [WORD_W-1:0]  w_mask;
    logic [WORD_W-1:0]  w_word_in;
    logic [7:0]         w_byte_num;
    logic [CHUNK_W-1:0] w_chunk_wr;

    assign w_accept = bus.s_valid & r_s_ready;
    assign w_xfer   = r_out_valid & ~bus.buffer_full;

    always_comb begin
        w_bytes_sat = (bus.s_bytes > 3'd4) ? 3'd4 : bus.s_bytes;
        w_mask      = bus.s_last ? last_word_mask(w_bytes_sat) : '1;
        w_word_in   = bus.s_word & w_mask;
        w_byte_num  = {1'b0, r_cnt, 2'b00} + {5'b0, w_bytes_sat};
        // Slots above cnt are already zero (chunk is cleared on every entry
        // to FILL), so masking the final word zeroes everything after it.
        w_chunk_wr  = r_chunk;
        for (int k = 0; k < SLOTS; k++) begin
            if (r_cnt == 5'(k)) begin
                w_chunk_wr[CHUNK_W-1-WORD_W*k -: WORD_W] = w_word_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_FILL;
            r_cnt        <= 5'd0;
            r_chunk      <= '0;
            r_last       <= 1'b0;
            r_pend_empty <= 1'b0;
            r_s_ready    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_byte_num   <= 8'd0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    r_s_ready <= 1'b1;
                    if (w_accept) begin
                        r_chunk <= w_chunk_wr;
                        r_cnt   <= r_cnt + 5'd1;
                        if (bus.s_last) begin
                            r_state     <= ST_HOLD;
                            r_s_ready   <= 1'b0;
                            r_out_valid <= 1'b1;
                            if (w_byte_num == FULL_BYTES) begin
                                // Full chunk is not the final one; an empty
                                // final chunk follows it.
                                r_last       <= 1'b0;
                                r_pend_empty <= 1'b1;
                                r_byte_num   <= 8'd0;
                            end else begin
                                r_last     <= 1'b1;
                                r_byte_num <= w_byte_num;
                            end
                        end else if (r_cnt == LAST_SLOT) begin
                            r_state     <= ST_HOLD;
                            r_s_ready   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_last      <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        if (r_last) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b0;
                        end else if (r_pend_empty) begin
                            r_chunk      <= '0;
                            r_byte_num   <= 8'd0;
                            r_last       <= 1'b1;
                            r_pend_empty <= 1'b0;
                        end else begin
                            r_state     <= ST_FILL;
                            r_cnt       <= 5'd0;
                            r_chunk     <= '0;
                            r_out_valid <= 1'b0;
                            r_s_ready   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_s_ready   <= 1'b0;
                    r_out_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.s_ready      = r_s_ready;
    assign bus.out          = r_chunk;
    assign bus.out_valid    = r_out_valid;
    // The padder samples is_last unconditionally, so qualify it with the
    // transfer condition.
    assign bus.out_last     = r_last & r_out_valid & ~bus.buffer_full;
    assign bus.out_byte_num = r_byte_num;

endmodule

`default_nettype wire

// File: tb/tb_keccak_input_packer.sv
// ============================================================================
//  Module      : tb_keccak_input_packer
//  Description : Directed self-checking bench for keccak_input_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keccak_input_packer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    keccak_input_packer_if #(.CHUNK_W(544), .WORD_W(32)) bus ();

    keccak_input_packer #(.CHUNK_W(544), .WORD_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [543:0] exp_chunk;

    task automatic chk(input string tag, input logic [543:0] act, input logic [543:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset           = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_last      = 1'b0;
        bus.s_bytes     = 3'd0;
        bus.buffer_full = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic l, input logic [2:0] b);
        int n = 0;
        bus.s_word  = w;
        bus.s_valid = 1'b1;
        bus.s_last  = l;
        bus.s_bytes = b;
        while (bus.s_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("send_timeout", 544'd0, 544'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_bytes = 3'd0;
    endtask

    task automatic xfer(input string tag, input logic exp_last);
        bus.buffer_full = 1'b0;
        #1;
        chk({tag, "_out_last"}, 544'(bus.out_last), 544'(exp_last));
        @(posedge clk);
        #1;
        bus.buffer_full = 1'b1;
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset           = 1'b0;
        bus.s_word      = 32'd0;
        bus.s_valid     = 1'b0;
        bus.s_last      = 1'b0;
        bus.s_bytes     = 3'd0;
        bus.buffer_full = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready",   544'(bus.s_ready), 544'd0);
        chk("rst_out_valid", 544'(bus.out_valid), 544'd0);
        chk("rst_out_last",  544'(bus.out_last), 544'd0);
        chk("rst_byte_num",  544'(bus.out_byte_num), 544'd0);
        chk("rst_out",       bus.out, 544'd0);
        bus.buffer_full = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rise_s_ready", 544'(bus.s_ready), 544'd1);

        // S1: 3-byte message
        send_word(32'hAABBCCDD, 1'b1, 3'd3);
        chk("s1_out_valid", 544'(bus.out_valid), 544'd1);
        chk("s1_s_ready",   544'(bus.s_ready), 544'd0);
        chk("s1_out",       bus.out, {32'hAABBCC00, 512'd0});
        chk("s1_byte_num",  544'(bus.out_byte_num), 544'd3);
        chk("s1_last_held", 544'(bus.out_last), 544'd0);
        xfer("s1", 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("s1_done_valid", 544'(bus.out_valid), 544'd0);
        chk("s1_done_ready", 544'(bus.s_ready), 544'd0);

        // S2 + S4: 17 full words, back-pressure, then a 2-byte final word
        apply_reset();
        for (int k = 1; k <= 17; k++) send_word(32'(k), 1'b0, 3'd0);
        exp_chunk = '0;
        for (int k = 0; k < 17; k++) exp_chunk[543-32*k -: 32] = 32'(k + 1);
        chk("s2_out_valid", 544'(bus.out_valid), 544'd1);
        chk("s2_out",       bus.out, exp_chunk);
        chk("s2_low_word",  544'(bus.out[31:0]), 544'h11);
        chk("s2_byte_num",  544'(bus.out_byte_num), 544'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("s4_out_stable", bus.out, exp_chunk);
            chk("s4_out_last",   544'(bus.out_last), 544'd0);
            chk("s4_s_ready",    544'(bus.s_ready), 544'd0);
            chk("s4_out_valid",  544'(bus.out_valid), 544'd1);
        end
        xfer("s2a", 1'b0);
        chk("s2_refill_ready", 544'(bus.s_ready), 544'd1);
        chk("s2_refill_valid", 544'(bus.out_valid), 544'd0);
        chk("s2_refill_out",   bus.out, 544'd0);
        send_word(32'h12345678, 1'b1, 3'd2);
        chk("s2b_out",      bus.out, {32'h12340000, 512'd0});
        chk("s2b_byte_num", 544'(bus.out_byte_num), 544'd2);
        xfer("s2b", 1'b1);
        chk("s2b_done_valid", 544'(bus.out_valid), 544'd0);

        // S3: exactly 68 bytes -> full chunk then empty final chunk
        apply_reset();
        for (int k = 0; k < 17; k++) send_word(32'hA000_0000 | 32'(k), k == 16, 3'd4);
        exp_chunk = '0;
        for (int k = 0; k < 17; k++) exp_chunk[543-32*k -: 32] = 32'hA000_0000 | 32'(k);
        chk("s3a_out",      bus.out, exp_chunk);
        chk("s3a_byte_num", 544'(bus.out_byte_num), 544'd0);
        xfer("s3a", 1'b0);
        chk("s3b_out_valid", 544'(bus.out_valid), 544'd1);
        chk("s3b_s_ready",   544'(bus.s_ready), 544'd0);
        chk("s3b_out",       bus.out, 544'd0);
        chk("s3b_byte_num",  544'(bus.out_byte_num), 544'd0);
        xfer("s3b", 1'b1);
        chk("s3b_done_valid", 544'(bus.out_valid), 544'd0);

        // S5: empty message
        apply_reset();
        send_word(32'hFFFFFFFF, 1'b1, 3'd0);
        chk("s5_out",      bus.out, 544'd0);
        chk("s5_byte_num", 544'(bus.out_byte_num), 544'd0);
        xfer("s5", 1'b1);

        // s_bytes above 4 saturates to a full word
        apply_reset();
        send_word(32'h11223344, 1'b1, 3'd7);
        chk("sat_out",      bus.out, {32'h11223344, 512'd0});
        chk("sat_byte_num", 544'(bus.out_byte_num), 544'd4);
        xfer("sat", 1'b1);

        // Final word after a full word: 4 + 1 bytes
        apply_reset();
        send_word(32'h01020304, 1'b0, 3'd0);
        send_word(32'h05060708, 1'b1, 3'd1);
        chk("two_out",      bus.out, {32'h01020304, 32'h05000000, 480'd0});
        chk("two_byte_num", 544'(bus.out_byte_num), 544'd5);
        xfer("two", 1'b1);

        // S6: reset mid-message, then a 1-byte message
        apply_reset();
        for (int k = 0; k < 9; k++) send_word(32'hC000_0000 | 32'(k), 1'b0, 3'd0);
        chk("s6_partial", 544'(bus.out[543:512]), 544'hC0000000);
        #2;
        reset = 1'b0;
        #1;
        chk("s6_rst_s_ready",   544'(bus.s_ready), 544'd0);
        chk("s6_rst_out",       bus.out, 544'd0);
        chk("s6_rst_out_valid", 544'(bus.out_valid), 544'd0);
        chk("s6_rst_byte_num",  544'(bus.out_byte_num), 544'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'hDEADBEEF, 1'b1, 3'd1);
        chk("s6_out",      bus.out, {32'hDE000000, 512'd0});
        chk("s6_byte_num", 544'(bus.out_byte_num), 544'd1);
        xfer("s6", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keccak_input_packer.md
KECCAK_INPUT_PACKER -- requirements
Module: keccak_input_packer

Interface
REQ-001 SHALL have parameter CHUNK_W, default 544, meaning the bit width of one padder input chunk.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the bit width of one message word.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s_word, input, 32, message word; byte 0 of the word is s_word[31:24].
REQ-006 SHALL have port s_valid, input, 1, meaning s_word is presented.
REQ-007 SHALL have port s_last, input, 1, meaning this is the final word of the message; qualified by s_valid.
REQ-008 SHALL have port s_bytes, input, 3, giving the count of valid bytes in the final word (0..4); values 5..7 SHALL be treated as 4; ignored when s_last=0.
REQ-009 SHALL have port s_ready, output, 1, meaning a word is accepted this cycle when s_valid=1.
REQ-010 SHALL have port out, output, 544, the chunk to the padder (its in); word k of the chunk occupies out[543-32k -: 32].
REQ-011 SHALL have port out_valid, output, 1, driving the padder's in_ready.
REQ-012 SHALL have port out_last, output, 1, driving the padder's is_last.
REQ-013 SHALL have port out_byte_num, output, 8, giving the valid bytes in the final chunk (0..67).
REQ-014 SHALL have port buffer_full, input, 1, from the padder; a transfer occurs in any cycle with out_valid=1 and buffer_full=0.

Function
REQ-015 SHALL implement the states FILL, HOLD and DONE, plus a 5-bit word counter cnt (0..16), a last flag and a pend_empty flag.
REQ-016 In FILL, s_ready SHALL be 1; an accepted word SHALL be written to chunk slot cnt and cnt SHALL increment.
REQ-017 On an accepted word with s_last=0 and cnt=16, the block SHALL go to HOLD with last=0.
REQ-018 On an accepted word with s_last=1, the block SHALL set out_byte_num = 4*cnt + s_bytes and zero all bytes after the last valid byte, including any unused slots.
REQ-019 On an accepted s_last word where out_byte_num < 68, the block SHALL go to HOLD with last=1.
REQ-020 On an accepted s_last word where the chunk is exactly full (cnt=16, s_bytes=4), the block SHALL go to HOLD with last=0 and pend_empty=1.
REQ-021 In HOLD, s_ready SHALL be 0 and out_valid SHALL be 1, with out held stable until transfer.
REQ-022 out_last SHALL equal last AND out_valid AND NOT buffer_full, so that it asserts only in the transfer cycle; the padder latches is_last unconditionally.
REQ-023 On a HOLD transfer with last=1, the block SHALL go to DONE.
REQ-024 On a HOLD transfer with pend_empty=1, the block SHALL stay in HOLD with out=0, out_byte_num=0, last=1 and pend_empty=0.
REQ-025 On any other HOLD transfer, the block SHALL go to FILL with cnt=0 and the chunk cleared.
REQ-026 In DONE, s_ready and out_valid SHALL be 0; the block SHALL remain in DONE until reset.
REQ-027 Latency: the word that completes a chunk SHALL be accepted at cycle t, with out_valid=1 at t+1; after a transfer at cycle u, s_ready SHALL be 1 at u+1.
REQ-028 An empty message (s_last with s_bytes=0 at cnt=0) SHALL yield a single final chunk with out_byte_num=0.
REQ-029 out_byte_num SHALL be 0 whenever last=0.

Reset
REQ-030 While reset=0, the block SHALL be in FILL with cnt=0, out=0, out_valid=0, out_last=0, out_byte_num=0, s_ready=0, last=0 and pend_empty=0.
REQ-031 s_ready SHALL rise on the first clock edge after reset is released.
REQ-032 Reset asserted mid-message SHALL discard the partial chunk and any pending chunk.

Structure
REQ-033 Constants K_RATE=1088, CHUNK_W=544, CHUNK_WORDS=17 and CHUNK_BYTES=68 SHALL reside in shared package keccak_pkg, together with the state enum.
REQ-034 The block SHALL have no sub-module; the last-word byte mask SHALL be a package function last_word_mask(s_bytes).

Verification
REQ-035 Scenario 1: a 3-byte message, word 0xAABBCCDD with s_last=1 and s_bytes=3 -> one chunk with out[543:512]=0xAABBCC00, all other bits 0, out_byte_num=3 and out_last=1 in the transfer cycle, then DONE.
REQ-036 Scenario 2: 17 words 0x00000001..0x00000011 followed by s_last word 0x12345678 with s_bytes=2 -> chunk 1 with out_last=0, out[31:0]=0x11; chunk 2 with out[543:512]=0x12340000 and out_byte_num=2.
REQ-037 Scenario 3: exactly 68 bytes (17 words, the last with s_last=1 and s_bytes=4) -> one full chunk with out_last=0, then an all-zero chunk with out_last=1 and out_byte_num=0.
REQ-038 Scenario 4: hold buffer_full=1 for 5 cycles while in HOLD -> out stable, out_last=0, s_ready=0; transfer in the first cycle with buffer_full=0.
REQ-039 Scenario 5: empty message (s_last=1, s_bytes=0) -> one chunk out=0, out_byte_num=0, out_last=1.
REQ-040 Scenario 6: reset asserted after 9 words -> outputs reach reset values immediately; a following 1-byte message produces a correct single chunk with out_byte_num=1.
